// File: rtl/cache_wb_assoc.sv
// N-way set-associative write-back / write-allocate cache with true LRU and flush-by-address.
// Optional `CACHE_STATS_EN adds hit_count / miss_count / wb_count outputs.
module cache_wb_assoc #(
    parameter int WORD_SELECT_BIT = 3,
    parameter int INDEX_BIT       = 2,
    parameter int NASSOC          = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  rw_flag_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] write_data_in,
    input  logic [3:0]  write_mask_in,
    output logic [31:0] read_data,
    output logic        busy,
    output logic        done,
    input  logic        flush_flag,
    input  logic [31:0] flush_addr,
    output logic [1:0]  mem_rw_flag,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_read_data,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_write_mask,
    input  logic        mem_busy,
    input  logic        mem_done
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [31:0] wb_count
`endif
);

    localparam int WORDS  = 1 << WORD_SELECT_BIT;
    localparam int SETS   = 1 << INDEX_BIT;
    localparam int TAG_W  = 32 - WORD_SELECT_BIT - INDEX_BIT - 2;
    localparam int WAY_W  = (NASSOC > 1) ? $clog2(NASSOC) : 1;
    localparam int IDX_LO = WORD_SELECT_BIT + 2;
    localparam int TAG_LO = WORD_SELECT_BIT + INDEX_BIT + 2;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOOKUP    = 3'd1;
    localparam logic [2:0] S_HIT_RESP  = 3'd2;
    localparam logic [2:0] S_WRITEBACK = 3'd3;
    localparam logic [2:0] S_REFILL    = 3'd4;
    localparam logic [2:0] S_FLUSH_WB  = 3'd5;

    logic [31:0]       data_mem [SETS][NASSOC][WORDS];
    logic [TAG_W-1:0]  tag_mem  [SETS][NASSOC];
    logic [NASSOC-1:0] valid_q  [SETS];
    logic [NASSOC-1:0] dirty_q  [SETS];
    logic [WAY_W-1:0]  age_q    [SETS][NASSOC];

    logic [2:0]                 state;
    logic                       req_write;
    logic                       req_flush;
    logic [31:0]                req_addr;
    logic [31:0]                req_wdata;
    logic [3:0]                 req_mask;
    logic [WAY_W-1:0]           req_way;
    logic [WORD_SELECT_BIT-1:0] word_cnt;
    logic                       mem_pending;

    logic [INDEX_BIT-1:0]       idx;
    logic [TAG_W-1:0]           req_tag;
    logic [WORD_SELECT_BIT-1:0] req_word;
    logic                       unused_lsb;

    assign idx        = req_addr[IDX_LO +: INDEX_BIT];
    assign req_tag    = req_addr[TAG_LO +: TAG_W];
    assign req_word   = req_addr[2 +: WORD_SELECT_BIT];
    assign unused_lsb = ^req_addr[1:0];

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim_way;
    logic [WAY_W-1:0] acc_way;
    logic [WAY_W-1:0] lru_next [NASSOC];
    logic [31:0]      cur_word;
    logic [31:0]      merged_word;
    logic             lookup_rw;
    logic             store_en;
    logic             refill_beat;
    logic             burst_last;
    logic             victim_dirty;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        victim_way = '0;
        // Descending scans leave the lowest matching index as the winner.
        for (int w = NASSOC - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && tag_mem[idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = 0; w < NASSOC; w++) begin
            if (age_q[idx][w] == WAY_W'(NASSOC - 1)) victim_way = WAY_W'(w);
        end
        for (int w = NASSOC - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) victim_way = WAY_W'(w);
        end
    end

    assign acc_way      = (state == S_LOOKUP) ? hit_way : req_way;
    assign cur_word     = data_mem[idx][acc_way][req_word];
    assign lookup_rw    = (state == S_LOOKUP) && !req_flush;
    assign store_en     = req_write && ((lookup_rw && hit) || state == S_HIT_RESP);
    assign refill_beat  = (state == S_REFILL) && mem_pending && mem_done;
    assign burst_last   = &word_cnt;
    assign victim_dirty = valid_q[idx][victim_way] && dirty_q[idx][victim_way];

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            merged_word[8*b +: 8] = req_mask[b] ? req_wdata[8*b +: 8] : cur_word[8*b +: 8];
        end
    end

    // Touched way becomes youngest; only ways younger than it age by one.
    always_comb begin
        for (int w = 0; w < NASSOC; w++) begin
            lru_next[w] = age_q[idx][w];
            if (WAY_W'(w) == acc_way) lru_next[w] = '0;
            else if (age_q[idx][w] < age_q[idx][acc_way]) lru_next[w] = age_q[idx][w] + 1'b1;
        end
    end

    // NOTE: data and tag storage carry no reset; valid bits alone decide whether contents matter.
    always_ff @(posedge clk) begin
        if (refill_beat) data_mem[idx][req_way][word_cnt] <= mem_read_data;
        if (store_en) data_mem[idx][acc_way][req_word] <= merged_word;
        if (refill_beat && burst_last) tag_mem[idx][req_way] <= req_tag;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            read_data      <= '0;
            mem_rw_flag    <= 2'b00;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_write_mask <= 4'h0;
            req_write      <= 1'b0;
            req_flush      <= 1'b0;
            req_addr       <= '0;
            req_wdata      <= '0;
            req_mask       <= 4'h0;
            req_way        <= '0;
            word_cnt       <= '0;
            mem_pending    <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < NASSOC; w++) age_q[s][w] <= WAY_W'(w);
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (flush_flag || rw_flag_in != 2'b00) begin
                        req_flush <= flush_flag;
                        req_write <= !flush_flag && rw_flag_in[1];
                        req_addr  <= flush_flag ? flush_addr : addr_in;
                        req_wdata <= write_data_in;
                        req_mask  <= write_mask_in;
                        busy      <= 1'b1;
                        state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (req_flush) begin
                        if (hit && dirty_q[idx][hit_way]) begin
                            req_way  <= hit_way;
                            word_cnt <= '0;
                            state    <= S_FLUSH_WB;
                        end else begin
                            if (hit) valid_q[idx][hit_way] <= 1'b0;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end else if (hit) begin
                        for (int w = 0; w < NASSOC; w++) age_q[idx][w] <= lru_next[w];
                        if (req_write) dirty_q[idx][hit_way] <= 1'b1;
                        else           read_data <= cur_word;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        req_way  <= victim_way;
                        word_cnt <= '0;
                        state    <= victim_dirty ? S_WRITEBACK : S_REFILL;
                    end
                end
                S_WRITEBACK, S_FLUSH_WB: begin
                    if (!mem_pending) begin
                        if (!mem_busy) begin
                            mem_rw_flag    <= 2'b10;
                            mem_addr       <= {tag_mem[idx][req_way], idx, word_cnt, 2'b00};
                            mem_write_data <= data_mem[idx][req_way][word_cnt];
                            mem_write_mask <= 4'hF;
                            mem_pending    <= 1'b1;
                        end
                    end else if (mem_done) begin
                        mem_rw_flag <= 2'b00;
                        mem_pending <= 1'b0;
                        word_cnt    <= word_cnt + 1'b1;
                        if (burst_last) begin
                            dirty_q[idx][req_way] <= 1'b0;
                            if (state == S_FLUSH_WB) begin
                                valid_q[idx][req_way] <= 1'b0;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end else begin
                                state <= S_REFILL;
                            end
                        end
                    end
                end
                S_REFILL: begin
                    if (!mem_pending) begin
                        if (!mem_busy) begin
                            mem_rw_flag    <= 2'b01;
                            mem_addr       <= {req_tag, idx, word_cnt, 2'b00};
                            mem_write_mask <= 4'h0;
                            mem_pending    <= 1'b1;
                        end
                    end else if (mem_done) begin
                        mem_rw_flag <= 2'b00;
                        mem_pending <= 1'b0;
                        word_cnt    <= word_cnt + 1'b1;
                        if (burst_last) begin
                            valid_q[idx][req_way] <= 1'b1;
                            dirty_q[idx][req_way] <= 1'b0;
                            for (int w = 0; w < NASSOC; w++) age_q[idx][w] <= lru_next[w];
                            state <= S_HIT_RESP;
                        end
                    end
                end
                S_HIT_RESP: begin
                    if (req_write) dirty_q[idx][req_way] <= 1'b1;
                    else           read_data <= cur_word;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (lookup_rw && hit)  hit_count  <= hit_count + 32'd1;
            if (lookup_rw && !hit) miss_count <= miss_count + 32'd1;
            if ((lookup_rw && !hit && victim_dirty) ||
                (state == S_LOOKUP && req_flush && hit && dirty_q[idx][hit_way]))
                wb_count <= wb_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_wb_assoc.sv
// Directed bench for cache_wb_assoc: vector table plus multi-cycle sequences, with a
// behavioural word memory that logs every transaction it serves.
`timescale 1ns/1ps
module tb_cache_wb_assoc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  rw_flag_in = 2'b00;
    logic [31:0] addr_in = '0;
    logic [31:0] write_data_in = '0;
    logic [3:0]  write_mask_in = '0;
    logic [31:0] read_data;
    logic        busy;
    logic        done;
    logic        flush_flag = 1'b0;
    logic [31:0] flush_addr = '0;
    logic [1:0]  mem_rw_flag;
    logic [31:0] mem_addr;
    logic [31:0] mem_read_data = '0;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_mask;
    logic        mem_busy = 1'b0;
    logic        mem_done = 1'b0;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count, wb_count;
`endif

    cache_wb_assoc dut (
        .clk(clk), .rst(rst),
        .rw_flag_in(rw_flag_in), .addr_in(addr_in),
        .write_data_in(write_data_in), .write_mask_in(write_mask_in),
        .read_data(read_data), .busy(busy), .done(done),
        .flush_flag(flush_flag), .flush_addr(flush_addr),
        .mem_rw_flag(mem_rw_flag), .mem_addr(mem_addr),
        .mem_read_data(mem_read_data), .mem_write_data(mem_write_data),
        .mem_write_mask(mem_write_mask), .mem_busy(mem_busy), .mem_done(mem_done)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int proto_err = 0;
    int mem_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    typedef struct packed {
        logic [1:0]  rw;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_op_t;

    mem_op_t     mem_log[$];
    logic [31:0] mem_store [logic [31:0]];
    mem_op_t     cur_op;
    logic        mem_active = 1'b0;
    int          mem_wait = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic mem_op_t log_at(input int i);
        if (i < mem_log.size()) return mem_log[i];
        return '0;
    endfunction

    always @(posedge clk) begin
        #1;
        mem_done = 1'b0;
        if (rst) begin
            mem_active = 1'b0;
        end else if (mem_active) begin
            if (mem_rw_flag !== cur_op.rw || mem_addr !== cur_op.addr) mem_err++;
            mem_wait--;
            if (mem_wait == 0) begin
                if (cur_op.rw == 2'b10) mem_store[cur_op.addr] = cur_op.data;
                else                    mem_read_data = mem_rd(cur_op.addr);
                mem_done   = 1'b1;
                mem_active = 1'b0;
            end
        end else if (mem_rw_flag != 2'b00) begin
            if (mem_busy) mem_err++;
            if (mem_rw_flag == 2'b10 && mem_write_mask !== 4'hF) mem_err++;
            cur_op     = '{rw: mem_rw_flag, addr: mem_addr, data: mem_write_data};
            mem_log.push_back(cur_op);
            mem_active = 1'b1;
            mem_wait   = 2;
        end
    end

    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && done) proto_err++;
            if (done && prev_done) proto_err++;
        end
        prev_done = done;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- CPU-side helpers ----------------
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 1000) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: no done after %0d cycles, expected a pulse", lat);
        end
    endtask

    task automatic cpu_req(input logic [1:0] rw, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] m, input logic fl, input logic [31:0] fa,
                           output int lat, output logic [31:0] rd);
        @(negedge clk);
        rw_flag_in = rw; addr_in = a; write_data_in = wd; write_mask_in = m;
        flush_flag = fl; flush_addr = fa;
        @(posedge clk); #1;
        rw_flag_in = 2'b00;
        flush_flag = 1'b0;
        wait_done(lat);
        rd = read_data;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        bit          chk_rd;
        logic [31:0] exp_rd;
        int          exp_ops;
        logic [31:0] exp_base;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int          lat, n0, cyc;
        logic [31:0] rd;
        mem_op_t     op;

        mem_store[32'h100] = 32'h1122_3344;

        // Index 0 lines sit at multiples of 0x80; 0x0A0 is index 1.
        vecs[0]  = '{2'b01, 32'h100, 32'h0,        4'h0, 1'b1, 32'h1122_3344, 8, 32'h100};
        vecs[1]  = '{2'b01, 32'h104, 32'h0,        4'h0, 1'b1, 32'hC0DE_0104, 0, 32'h0};
        vecs[2]  = '{2'b10, 32'h100, 32'hAABBCCDD, 4'h3, 1'b0, 32'h0,         0, 32'h0};
        vecs[3]  = '{2'b01, 32'h100, 32'h0,        4'h0, 1'b1, 32'h1122_CCDD, 0, 32'h0};
        vecs[4]  = '{2'b01, 32'h11C, 32'h0,        4'h0, 1'b1, 32'hC0DE_011C, 0, 32'h0};
        vecs[5]  = '{2'b01, 32'h0A0, 32'h0,        4'h0, 1'b1, 32'hC0DE_00A0, 8, 32'h0A0};
        vecs[6]  = '{2'b10, 32'h0A4, 32'h12345678, 4'hF, 1'b0, 32'h0,         0, 32'h0};
        vecs[7]  = '{2'b01, 32'h0A4, 32'h0,        4'h0, 1'b1, 32'h1234_5678, 0, 32'h0};
        vecs[8]  = '{2'b01, 32'h000, 32'h0,        4'h0, 1'b1, 32'hC0DE_0000, 8, 32'h000};
        vecs[9]  = '{2'b01, 32'h180, 32'h0,        4'h0, 1'b1, 32'hC0DE_0180, 8, 32'h180};
        vecs[10] = '{2'b01, 32'h200, 32'h0,        4'h0, 1'b1, 32'hC0DE_0200, 8, 32'h200};
        vecs[11] = '{2'b01, 32'h108, 32'h0,        4'h0, 1'b1, 32'hC0DE_0108, 0, 32'h0};
        vecs[12] = '{2'b01, 32'h280, 32'h0,        4'h0, 1'b1, 32'hC0DE_0280, 8, 32'h280};
        vecs[13] = '{2'b01, 32'h100, 32'h0,        4'h0, 1'b1, 32'h1122_CCDD, 0, 32'h0};
        vecs[14] = '{2'b01, 32'h184, 32'h0,        4'h0, 1'b1, 32'hC0DE_0184, 0, 32'h0};
        vecs[15] = '{2'b01, 32'h000, 32'h0,        4'h0, 1'b1, 32'hC0DE_0000, 8, 32'h000};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst busy", {31'b0, busy}, 32'h0);
        check("rst done", {31'b0, done}, 32'h0);
        check("rst read_data", read_data, 32'h0);
        check("rst mem_rw_flag", {30'b0, mem_rw_flag}, 32'h0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_write_data", mem_write_data, 32'h0);
        check("rst mem_write_mask", {28'b0, mem_write_mask}, 32'h0);
        rst = 1'b0;

        // Table: fills, hits, byte-merge, LRU eviction of the second-oldest line
        for (int i = 0; i < 16; i++) begin
            n0 = mem_log.size();
            cpu_req(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].mask, 1'b0, 32'h0, lat, rd);
            check($sformatf("v%0d mem ops", i), 32'(mem_log.size() - n0), 32'(vecs[i].exp_ops));
            if (vecs[i].chk_rd) check($sformatf("v%0d read_data", i), rd, vecs[i].exp_rd);
            if (vecs[i].exp_ops == 0) check($sformatf("v%0d hit latency", i), 32'(lat), 32'd1);
            for (int k = 0; k < vecs[i].exp_ops; k++) begin
                op = log_at(n0 + k);
                check($sformatf("v%0d op%0d rw", i, k), {30'b0, op.rw}, 32'h1);
                check($sformatf("v%0d op%0d addr", i, k), op.addr, vecs[i].exp_base + 32'(4 * k));
            end
        end
`ifdef CACHE_STATS_EN
        check("stats hit_count", hit_count, 32'd9);
        check("stats miss_count", miss_count, 32'd7);
        check("stats wb_count", wb_count, 32'd0);
`endif

        // Dirty victim: 8 writebacks of old line precede 8 refill reads
        do_reset();
        cpu_req(2'b10, 32'h040, 32'h55AA55AA, 4'hF, 1'b0, 32'h0, lat, rd);
        cpu_req(2'b01, 32'h0C0, 32'h0, 4'h0, 1'b0, 32'h0, lat, rd);
        cpu_req(2'b01, 32'h140, 32'h0, 4'h0, 1'b0, 32'h0, lat, rd);
        cpu_req(2'b01, 32'h1C0, 32'h0, 4'h0, 1'b0, 32'h0, lat, rd);
        n0 = mem_log.size();
        cpu_req(2'b01, 32'h240, 32'h0, 4'h0, 1'b0, 32'h0, lat, rd);
        check("evict mem ops", 32'(mem_log.size() - n0), 32'd16);
        op = log_at(n0);
        check("evict wb0 rw", {30'b0, op.rw}, 32'h2);
        check("evict wb0 addr", op.addr, 32'h040);
        check("evict wb0 data", op.data, 32'h55AA55AA);
        op = log_at(n0 + 7);
        check("evict wb7 addr", op.addr, 32'h05C);
        check("evict wb7 data", op.data, 32'hC0DE_005C);
        op = log_at(n0 + 8);
        check("evict rf0 rw", {30'b0, op.rw}, 32'h1);
        check("evict rf0 addr", op.addr, 32'h240);
        op = log_at(n0 + 15);
        check("evict rf7 addr", op.addr, 32'h25C);
        check("evict read_data", rd, 32'hC0DE_0240);
        n0 = mem_log.size();
        cpu_req(2'b01, 32'h040, 32'h0, 4'h0, 1'b0, 32'h0, lat, rd);
        check("evicted reread ops", 32'(mem_log.size() - n0), 32'd8);
        check("evicted reread data", rd, 32'h55AA55AA);

        // Flush: dirty, clean, absent
        do_reset();
        cpu_req(2'b10, 32'h100, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, lat, rd);
        n0 = mem_log.size();
        cpu_req(2'b00, 32'h0, 32'h0, 4'h0, 1'b1, 32'h100, lat, rd);
        check("flush dirty ops", 32'(mem_log.size() - n0), 32'd8);
        op = log_at(n0);
        check("flush wb0 addr", op.addr, 32'h100);
        check("flush wb0 data", op.data, 32'hCAFEF00D);
        op = log_at(n0 + 7);
        check("flush wb7 rw", {30'b0, op.rw}, 32'h2);
        check("flush wb7 addr", op.addr, 32'h11C);
        check("flush read_data held", rd, 32'h0);
        n0 = mem_log.size();
        cpu_req(2'b01, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, lat, rd);
        check("post-flush reread ops", 32'(mem_log.size() - n0), 32'd8);
        check("post-flush reread data", rd, 32'hCAFEF00D);
        n0 = mem_log.size();
        cpu_req(2'b00, 32'h0, 32'h0, 4'h0, 1'b1, 32'h100, lat, rd);
        check("flush clean ops", 32'(mem_log.size() - n0), 32'd0);
        cpu_req(2'b00, 32'h0, 32'h0, 4'h0, 1'b1, 32'h300, lat, rd);
        check("flush absent ops", 32'(mem_log.size() - n0), 32'd0);
        cpu_req(2'b01, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, lat, rd);
        check("clean-flush reread ops", 32'(mem_log.size() - n0), 32'd8);

        // Flush and read together: flush wins, read dropped
        n0 = mem_log.size();
        cpu_req(2'b01, 32'h0A0, 32'h0, 4'h0, 1'b1, 32'h100, lat, rd);
        check("flush+read ops", 32'(mem_log.size() - n0), 32'd0);
        check("flush+read read_data", rd, 32'hCAFEF00D);
        cpu_req(2'b01, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, lat, rd);
        check("flush+read reread ops", 32'(mem_log.size() - n0), 32'd8);

        // mem_busy held high: no request may appear
        do_reset();
        @(negedge clk);
        mem_busy = 1'b1;
        rw_flag_in = 2'b01; addr_in = 32'h300;
        @(posedge clk); #1;
        rw_flag_in = 2'b00;
        n0 = mem_log.size();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("mem_busy hold %0d", k), {30'b0, mem_rw_flag}, 32'h0);
        end
        @(negedge clk);
        mem_busy = 1'b0;
        wait_done(lat);
        check("mem_busy release ops", 32'(mem_log.size() - n0), 32'd8);
        check("mem_busy release data", read_data, 32'hC0DE_0300);

        // Reset asserted mid-refill aborts immediately
        @(negedge clk);
        rw_flag_in = 2'b01; addr_in = 32'h380;
        @(posedge clk); #1;
        rw_flag_in = 2'b00;
        n0 = mem_log.size();
        cyc = 0;
        while (!(mem_log.size() >= n0 + 2 && mem_rw_flag == 2'b01) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("mid-refill busy", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        check("abort mem_rw_flag", {30'b0, mem_rw_flag}, 32'h0);
        check("abort busy", {31'b0, busy}, 32'h0);
        check("abort done", {31'b0, done}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n0 = mem_log.size();
        cpu_req(2'b01, 32'h380, 32'h0, 4'h0, 1'b0, 32'h0, lat, rd);
        check("post-abort ops", 32'(mem_log.size() - n0), 32'd8);
        check("post-abort data", rd, 32'hC0DE_0380);

        repeat (4) @(negedge clk);
        check("done/busy protocol", 32'(proto_err), 32'h0);
        check("memory handshake", 32'(mem_err), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
